// File: rtl/bpu_imm_pkg.sv
// Shared immediate-format encodings for the branch/immediate datapath.
// Pure declarations; no timing or flow-control content.
package bpu_imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4,
        IMM_Z = 3'd5
    } imm_src_e;

    // Encodings 6 and 7 are reserved and flagged as illegal downstream.
    function automatic logic imm_src_legal(input logic [2:0] src);
        return src <= IMM_Z;
    endfunction

endpackage

// File: rtl/imm_decode_core.sv
// Combinational immediate extractor plus pc-relative target adder.
// Zero latency; no flow control of its own.
module imm_decode_core
    import bpu_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      imm_src,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    imm_src_e   src;
    logic [31:0] imm32;
    logic        unused_opcode;

    assign src           = imm_src_e'(imm_src);
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm32 = '0;
        case (src)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'h000};
            IMM_Z:   imm32 = {27'd0, instr[19:15]};
            default: imm32 = '0;
        endcase
    end

    // Z is already zero in bit 31, so one signed widening serves every format.
    assign imm     = XLEN'($signed(imm32));
    assign target  = pc + imm;
    assign illegal = !imm_src_legal(imm_src);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate decode + branch target, registered through an output/skid pair.
// Latency 1 cycle; in_ready is registered and drops once the skid entry is occupied.
module imm_gen_pipe
    import bpu_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_imm_src,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            illegal;
    } res_t;

    logic [XLEN-1:0]  dec_imm;
    logic [XLEN-1:0]  dec_target;
    logic             dec_illegal;
    res_t             dec_res;
    res_t             out_q;
    res_t             skid_q;
    logic             out_vld_q;
    logic             skid_vld_q;
    logic             skid_vld_d;
    logic             in_rdy_q;
    logic             accept;
    logic             consume;
    logic             out_free;
    logic [CNT_W-1:0] cnt_q;

    imm_decode_core #(.XLEN(XLEN)) u_decode (
        .imm_src (in_imm_src),
        .instr   (in_instr),
        .pc      (in_pc),
        .imm     (dec_imm),
        .target  (dec_target),
        .illegal (dec_illegal)
    );

    assign dec_res  = '{imm: dec_imm, target: dec_target, illegal: dec_illegal};
    assign accept   = in_valid && in_rdy_q;
    assign consume  = out_vld_q && out_ready;
    assign out_free = !out_vld_q || consume;

    // The skid only fills when the output slot is held; in_ready guarantees
    // no accept can arrive while it is already full.
    always_comb begin
        skid_vld_d = skid_vld_q;
        if (skid_vld_q) begin
            skid_vld_d = !out_free;
        end else begin
            skid_vld_d = accept && !out_free;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_q      <= '0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
            in_rdy_q   <= 1'b1;
            cnt_q      <= '0;
        end else begin
            if (out_free) begin
                if (skid_vld_q) begin
                    out_q     <= skid_q;
                    out_vld_q <= 1'b1;
                end else begin
                    out_vld_q <= accept;
                    if (accept) begin
                        out_q <= dec_res;
                    end
                end
            end
            if (accept && !out_free) begin
                skid_q <= dec_res;
            end
            skid_vld_q <= skid_vld_d;
            in_rdy_q   <= !skid_vld_d;
            if (accept && dec_illegal && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready    = in_rdy_q;
    assign out_valid   = out_vld_q;
    assign out_imm     = out_q.imm;
    assign out_target  = out_q.target;
    assign out_illegal = out_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule
